// File: rtl/tx_byte_fifo.sv
// ---------------------------------------------------------------------------
// tx_byte_fifo
//   Byte FIFO between the CPU TX staging buffer (tx_cpu_buf) and the TX
//   serializer. It accepts one byte per clock from the staging buffer and
//   returns has_space as that buffer's fifo_has_space input. It presents
//   bytes first-word-fall-through on a valid/ready port and reports the
//   current fill level.
//
//   Optional feature: define TX_FIFO_WATERMARK_EN to make low_water a
//   registered "level <= LOW_WATER" flag, which the CPU side uses as its
//   refill interrupt source. If the macro is undefined, low_water is tied
//   to 0 and the LOW_WATER parameter is ignored.
//
// Parameters
//   ADDR_W     log2 of the depth, DEPTH = 1 << ADDR_W (ADDR_W >= 1)
//   LOW_WATER  low-water threshold in bytes, 0..DEPTH
//
// Ports
//   clk        single clock; all logic runs on the rising edge
//   reset_n    synchronous active-low reset; has priority over flush
//   flush      synchronous clear of the FIFO contents
//   in_data    byte offered by the staging buffer
//   in_valid   the staging buffer is offering a byte
//   has_space  the FIFO can accept in_data this cycle
//   out_data   head byte; its value is don't-care while out_valid = 0
//   out_valid  a head byte is present
//   out_ready  the serializer takes the head byte this cycle
//   level      number of bytes stored, 0..DEPTH
//   low_water  level <= LOW_WATER (only with TX_FIFO_WATERMARK_EN)
// ---------------------------------------------------------------------------
module tx_byte_fifo #(
  parameter int ADDR_W    = 4,
  parameter int LOW_WATER = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              has_space,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   level,
  output logic              low_water
);

  localparam int              DEPTH      = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic [ADDR_W:0]   w_level_next;
  logic              w_push;
  logic              w_pop;

  // has_space is built only from the registered level and the two
  // sideband inputs. As a result, no combinational path runs from out_ready
  // back to the staging buffer. A full FIFO that pops this cycle opens up
  // space only in the following cycle.
  assign has_space = reset_n & ~flush & (r_level != FULL_LEVEL);
  assign out_valid = reset_n & (r_level != '0);
  assign out_data  = r_mem[r_rd_ptr];
  assign level     = r_level;

  assign w_push = in_valid & has_space;
  assign w_pop  = out_valid & out_ready;

  always_comb begin
    // NOTE: a default assignment before the conditional updates keeps this
    // block purely combinational; without it, a latch would be inferred.
    w_level_next = r_level;
    if (w_push && !w_pop) begin
      w_level_next = r_level + 1'b1;
    end else if (!w_push && w_pop) begin
      w_level_next = r_level - 1'b1;
    end
  end

  // NOTE: the storage array has no reset. Every slot is written before it
  // can be read, because out_valid depends on the level. Leaving reset out
  // also allows the array to map onto RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // NOTE: all state registers use non-blocking assignments. Every flop then
  // samples its pre-edge value, whatever the order of evaluation.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      // A push cannot happen here because has_space is low. A pop in this
      // cycle is dropped on purpose.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      // The pointers are exactly ADDR_W bits wide, so they wrap from
      // DEPTH-1 to 0 without any extra logic.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_next;
    end
  end

`ifdef TX_FIFO_WATERMARK_EN
  localparam logic [ADDR_W:0] LW_THRESH = (ADDR_W + 1)'(LOW_WATER);

  logic r_low_water;

  // The flag is computed from the next level, so it agrees with level in
  // the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      r_low_water <= 1'b1;
    end else begin
      r_low_water <= (w_level_next <= LW_THRESH);
    end
  end

  assign low_water = r_low_water;
`else
  // The threshold has no effect in this build. Referencing it here keeps
  // the parameter visibly consumed.
  logic w_unused_low_water;
  assign w_unused_low_water = (LOW_WATER != 0);
  assign low_water          = 1'b0;
`endif

endmodule

// File: tb/tb_tx_byte_fifo.sv
// ---------------------------------------------------------------------------
// tb_tx_byte_fifo
//   Self-checking bench for tx_byte_fifo. The reference model is a byte
//   queue: its size is the expected level, and its front is the expected
//   head byte. A compare process checks every DUT output against the model
//   on each falling edge. Directed sequences add literal expectations for
//   reset, single bytes, full-FIFO behaviour, flush and the watermark. A
//   randomized stream checks byte order across pointer wrap.
// ---------------------------------------------------------------------------
module tb_tx_byte_fifo;

  localparam int ADDR_W    = 4;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int LOW_WATER = 4;
`ifdef TX_FIFO_WATERMARK_EN
  localparam bit WM = 1'b1;
`else
  localparam bit WM = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic            flush;
  logic [7:0]      in_data;
  logic            in_valid;
  logic            has_space;
  logic [7:0]      out_data;
  logic            out_valid;
  logic            out_ready;
  logic [ADDR_W:0] level;
  logic            low_water;

  always #5 clk = ~clk;

  tx_byte_fifo #(
    .ADDR_W    (ADDR_W),
    .LOW_WATER (LOW_WATER)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .has_space (has_space),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .low_water (low_water)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  byte unsigned model_q[$];
  bit           model_lw;
  bit           model_known = 1'b0;
  bit           m_push;
  bit           m_pop;

  always @(posedge clk) begin
    if (!reset_n) begin
      model_q.delete();
      model_lw    = 1'b1;
      model_known = 1'b1;
    end else if (model_known) begin
      if (flush) begin
        model_q.delete();
        model_lw = 1'b1;
      end else begin
        m_push = in_valid && (model_q.size() < DEPTH);
        m_pop  = out_ready && (model_q.size() > 0);
        if (m_pop)  void'(model_q.pop_front());
        if (m_push) model_q.push_back(in_data);
        model_lw = (model_q.size() <= LOW_WATER);
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (model_known) begin
      check("has_space", has_space, reset_n && !flush && (model_q.size() != DEPTH));
      check("out_valid", out_valid, reset_n && (model_q.size() > 0));
      check("level", level, model_q.size());
      check("low_water", low_water, WM ? model_lw : 1'b0);
      if (reset_n && model_q.size() > 0) check("out_data", out_data, model_q[0]);
    end
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL timeout: got no finish, expected finish before 500000");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int       sent;
  int       recv;
  bit       seen5;
  bit       push_now;
  bit       pop_now;
  bit [4:0] lvl_before;

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    out_ready = 1'b0;

    // Reset holds off the upstream byte.
    repeat (3) begin
      tick();
      check("rst_has_space", has_space, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_level", level, 0);
    end
    reset_n = 1'b1;
    #1 check("post_rst_has_space", has_space, 1'b1);
    tick();
    in_valid = 1'b0;
    check("post_rst_level", level, 1);
    check("post_rst_head", out_data, 8'h11);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_rst_drain", level, 0);

    // Single byte, latency 1.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick();
    in_valid = 1'b0;
    check("single_valid", out_valid, 1'b1);
    check("single_data", out_data, 8'hA5);
    check("single_level", level, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("single_pop_valid", out_valid, 1'b0);
    check("single_pop_level", level, 0);

    // Full FIFO: a pop does not admit a push in the same cycle.
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      tick();
    end
    in_data = 8'hFF;
    check("full_level", level, 16);
    check("full_has_space", has_space, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("full_pop_level", level, 15);
    check("full_pop_space", has_space, 1'b1);
    check("full_pop_head", out_data, 8'h01);
    tick();
    in_valid = 1'b0;
    check("full_refill_level", level, 16);
    for (int k = 0; k < DEPTH; k++) begin
      check("full_drain_order", out_data, (k < DEPTH - 1) ? 8'(k + 1) : 8'hFF);
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    check("full_drained", level, 0);

    // Random stream of 40 bytes with continuous in_valid.
    sent  = 0;
    recv  = 0;
    seen5 = 1'b0;
    for (int cyc = 0; cyc < 2000 && recv < 40; cyc++) begin
      in_valid   = (sent < 40);
      in_data    = 8'(sent);
      out_ready  = ($urandom_range(0, 2) == 0);
      push_now   = in_valid && has_space;
      pop_now    = out_valid && out_ready;
      lvl_before = level;
      if (pop_now) begin
        check("stream_order", out_data, 8'(recv));
        recv++;
      end
      if (push_now) sent++;
      tick();
      if (push_now && pop_now && lvl_before == 5 && !seen5) begin
        seen5 = 1'b1;
        check("level5_push_pop", level, 5);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("stream_done", recv, 40);

    // Flush at level 7 with both sides active.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h30 + i);
      tick();
    end
    in_valid = 1'b0;
    check("pre_flush_level", level, 7);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h5C;
    out_ready = 1'b1;
    #1 check("flush_has_space", has_space, 1'b0);
    tick();
    flush     = 1'b0;
    out_ready = 1'b0;
    check("post_flush_level", level, 0);
    check("post_flush_valid", out_valid, 1'b0);
    tick();
    in_valid = 1'b0;
    check("post_flush_accept", level, 1);
    check("post_flush_head", out_data, 8'h5C);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Watermark crossing at LOW_WATER = 4.
    check("wm_empty", low_water, WM);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h60 + i);
      tick();
    end
    in_valid = 1'b0;
    check("wm_level5", low_water, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("wm_pop_to4", low_water, WM);
    in_valid = 1'b1;
    in_data  = 8'h65;
    tick();
    in_valid = 1'b0;
    check("wm_push_to5", low_water, 1'b0);

    // Reset mid-stream discards everything.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midrst_level", level, 0);
    check("midrst_valid", out_valid, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h77;
    tick();
    in_valid = 1'b0;
    check("midrst_new_head", out_data, 8'h77);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
